// File: rtl/contador_defs.sv
// Definitions shared by the counter query requester, the FIFO word counter
// (contador) and its probador: FSM encodings and default widths.
package contador_defs;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int DEF_CNT_W     = 5;
    localparam int DEF_IDX_W     = 3;
    localparam int DEF_NUM_FIFOS = 4;
    localparam int DEF_TIMEOUT   = 8;
endpackage

// File: rtl/timeout_timer.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// expiry at TIMEOUT-1. It saturates there so it can never wrap.
module timeout_timer #(
    parameter  int TIMEOUT = 8,
    localparam int TW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lector_contador.sv
// Counter query requester: on start (while IDLE) walks idx 0..NUM_FIFOS-1,
// captures each returned count into cnt_all, then pulses done (or error).
module lector_contador
    import contador_defs::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       IDLE,
    input  logic                       valid_contador,
    input  logic [CNT_W-1:0]           contador_out,
    output logic                       req,
    output logic [IDX_W-1:0]           idx,
    output logic [NUM_FIFOS*CNT_W-1:0] cnt_all,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);
    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_FIFOS*CNT_W-1:0] cnt_q, cnt_d;
    logic                       req_q, req_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;
    logic                       tmr_clear, tmr_en, tmr_expired;

    // The timer only runs inside S_WAIT, so it always starts from zero there.
    assign tmr_clear = (state_q != S_WAIT);
    assign tmr_en    = (state_q == S_WAIT) && IDLE && !valid_contador;

    timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && IDLE) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_REQ: begin
                if (!IDLE) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                // Losing IDLE wins over a same-cycle response: nothing is captured.
                if (!IDLE) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else if (valid_contador) begin
                    for (int i = 0; i < NUM_FIFOS; i++)
                        if (idx_q == IDX_W'(i))
                            cnt_d[i*CNT_W +: CNT_W] = contador_out;
                    if (idx_q == IDX_W'(NUM_FIFOS - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign req     = req_q;
    assign idx     = idx_q;
    assign cnt_all = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
endmodule

// File: tb/tb_lector_contador.sv
// Self-checking bench for lector_contador: table-driven sweeps against a
// responder model, with req/idx and done/error results scoreboarded.
module tb_lector_contador;
    localparam int N = 4, IW = 3, CW = 5, TO = 8;

    logic            clk, reset, start, IDLE, valid_contador;
    logic [CW-1:0]   contador_out;
    logic            req, busy, done, error;
    logic [IW-1:0]   idx;
    logic [N*CW-1:0] cnt_all;

    lector_contador #(.NUM_FIFOS(N), .IDX_W(IW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .IDLE(IDLE),
        .valid_contador(valid_contador), .contador_out(contador_out),
        .req(req), .idx(idx), .cnt_all(cnt_all), .busy(busy),
        .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][CW-1:0] c;
        int                 fail_idx;   // -1: clean sweep
        bit                 idle_loss;  // fail by IDLE drop instead of silence
        logic [N*CW-1:0]    exp_cnt;
    } vec_t;

    typedef struct {
        bit              err;
        logic [N*CW-1:0] cnt;
        int              cyc;
    } res_t;

    int      n_chk = 0, n_pass = 0, cycle = 0;
    int      exp_idx[$];
    res_t    res_q[$];
    vec_t    vt[8];
    logic    pend = 1'b0;
    logic [CW-1:0] pend_val = '0;
    logic [CW-1:0] resp_cnt[8];
    bit      resp_en[8];
    int      idle_drop_idx = -1;
    logic    idle_lvl = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycle);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cycle);
    endtask

    // One clock: drive the responder, then monitor the DUT 1ns after the edge.
    task automatic step();
        res_t r;
        @(posedge clk);
        #1;
        cycle++;
        valid_contador = pend;
        contador_out   = pend ? pend_val : '0;
        IDLE           = idle_lvl;
        if (pend && idle_drop_idx == int'(idx)) begin
            IDLE          = 1'b0;
            idle_drop_idx = -1;
        end
        pend     = req && resp_en[idx];
        pend_val = resp_cnt[idx];
        if (req) begin
            if (exp_idx.size() == 0) fail_now("req_unexpected");
            else check("req_idx", idx, exp_idx.pop_front());
        end
        if (done || error) begin
            if (res_q.size() == 0) fail_now("result_unexpected");
            else begin
                r = res_q.pop_front();
                check("result_is_error", error, r.err);
                check("result_is_done", done, !r.err);
                check("result_cnt_all", cnt_all, r.cnt);
                check("result_cycle", cycle, r.cyc);
            end
        end
    endtask

    task automatic set_idle(input logic v);
        idle_lvl = v;
        IDLE     = v;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (res_q.size() > 0 || exp_idx.size() > 0); k++) step();
        if (res_q.size() > 0 || exp_idx.size() > 0) begin
            fail_now("drain_timeout");
            res_q.delete();
            exp_idx.delete();
        end
    endtask

    task automatic load_resp(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            resp_cnt[i] = (i < 4) ? v.c[i] : '0;
            resp_en[i]  = (i < 4) && (v.idle_loss || v.fail_idx < 0 || i < v.fail_idx);
        end
        idle_drop_idx = v.idle_loss ? v.fail_idx : -1;
    endtask

    // Queue the expectations for a sweep whose start is sampled on the next edge.
    task automatic expect_sweep(input vec_t v, input int c0);
        res_t r;
        int   k = v.fail_idx;
        int   nreq = (k < 0) ? N : k + 1;
        for (int i = 0; i < nreq; i++) exp_idx.push_back(i);
        r.err = (k >= 0);
        r.cnt = v.exp_cnt;
        r.cyc = (k < 0) ? c0 + 2*N + 1 : (v.idle_loss ? c0 + 3 + 2*k : c0 + 2 + 2*k + TO);
        res_q.push_back(r);
    endtask

    task automatic run_row(input vec_t v, input string nm);
        load_resp(v);
        expect_sweep(v, cycle);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        step();
        step();
        check({nm, "_busy_after"}, busy, 0);
        check({nm, "_cnt_hold"}, cnt_all, v.exp_cnt);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_req"}, req, 0);
        check({nm, "_idx"}, idx, 0);
        check({nm, "_cnt_all"}, cnt_all, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_error"}, error, 0);
    endtask

    initial begin
        vt[0] = '{c: {5'd2, 5'd4, 5'd1, 5'd3},     fail_idx: -1, idle_loss: 0, exp_cnt: {5'd2, 5'd4, 5'd1, 5'd3}};
        vt[1] = '{c: {5'd1, 5'd31, 5'd0, 5'd7},    fail_idx: -1, idle_loss: 0, exp_cnt: {5'd1, 5'd31, 5'd0, 5'd7}};
        vt[2] = '{c: {5'd0, 5'd0, 5'd0, 5'd0},     fail_idx: -1, idle_loss: 0, exp_cnt: 20'd0};
        vt[3] = '{c: {5'd4, 5'd3, 5'd2, 5'd9},     fail_idx: 1,  idle_loss: 0, exp_cnt: {15'd0, 5'd9}};
        vt[4] = '{c: {5'd8, 5'd7, 5'd6, 5'd5},     fail_idx: 2,  idle_loss: 1, exp_cnt: {10'd0, 5'd6, 5'd5}};
        vt[5] = '{c: {5'd31, 5'd31, 5'd31, 5'd31}, fail_idx: -1, idle_loss: 0, exp_cnt: {4{5'd31}}};
        vt[6] = '{c: {5'd4, 5'd3, 5'd2, 5'd1},     fail_idx: 0,  idle_loss: 0, exp_cnt: 20'd0};
        vt[7] = '{c: {5'd13, 5'd12, 5'd11, 5'd10}, fail_idx: 3,  idle_loss: 0, exp_cnt: {5'd0, 5'd12, 5'd11, 5'd10}};

        reset = 1'b0; start = 1'b0; IDLE = 1'b0; valid_contador = 1'b0; contador_out = '0;
        load_resp(vt[0]);
        for (int i = 0; i < 3; i++) step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // start is ignored while IDLE is low, then honoured on the next edge.
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("gated_req", req, 0);
            check("gated_busy", busy, 0);
        end
        load_resp(vt[0]);
        expect_sweep(vt[0], cycle);
        set_idle(1'b1);
        step();
        start = 1'b0;
        check("ungated_busy", busy, 1);
        drain();
        step();

        for (int r = 0; r < 8; r++) run_row(vt[r], $sformatf("row%0d", r));

        // Asynchronous reset during the idx=1 wait clears everything at once.
        load_resp(vt[1]);
        exp_idx.push_back(0);
        exp_idx.push_back(1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("pre_reset_busy", busy, 1);
        check("pre_reset_idx", idx, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        pend = 1'b0;
        if (exp_idx.size() != 0) fail_now("reset_leftover_req");
        exp_idx.delete();
        step();
        check_all_zero("reset_held");
        reset = 1'b1;
        step();
        run_row(vt[0], "after_reset");

        // Back-to-back sweeps with start held high.
        load_resp(vt[1]);
        expect_sweep(vt[1], cycle);
        expect_sweep(vt[2], cycle + 2*N + 2);
        start = 1'b1;
        for (int k = 0; k < 40 && res_q.size() > 1; k++) step();
        check("b2b_first_done", res_q.size(), 1);
        load_resp(vt[2]);
        for (int k = 0; k < 40 && res_q.size() > 0; k++) step();
        start = 1'b0;
        check("b2b_second_done", res_q.size(), 0);
        drain();
        step();
        step();
        check("b2b_busy_after", busy, 0);
        check("b2b_cnt_zero", cnt_all, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lector_contador.md
Name: lector_contador

Overview:
- Requester end of the counter query interface. It drives req/idx into the FIFO word counter (contador) and collects the valid_contador/contador_out responses.
- On a start command, while the system reports IDLE, it walks idx 0..NUM_FIFOS-1. For each index it captures the returned count into a packed result register, then pulses done.
- It sits between the top-level control FSM and contador. It replaces the hand-driven req/idx sequencing used in bench stimulus.

Parameters:
- NUM_FIFOS, 4, number of FIFO counters queried per sweep (1..8).
- IDX_W, 3, width of idx; must satisfy 2**IDX_W >= NUM_FIFOS.
- CNT_W, 5, width of contador_out and of each captured count.
- TIMEOUT, 8, maximum cycles spent in WAIT for valid_contador before aborting (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  sweep request, level-sampled in S_IDLE only.
- IDLE  in  1  system idle indication; sweeps only start and continue while high.
- valid_contador  in  1  counter response strobe.
- contador_out  in  CNT_W  count for the currently requested idx.
- req  out  1  request to counter, one-cycle pulse per index.
- idx  out  IDX_W  FIFO index being queried.
- cnt_all  out  NUM_FIFOS*CNT_W  captured counts; FIFO i occupies bits [i*CNT_W +: CNT_W].
- busy  out  1  high in S_REQ/S_WAIT.
- done  out  1  one-cycle pulse on successful sweep.
- error  out  1  one-cycle pulse on timeout or IDLE-loss abort.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=S_IDLE.
  - req=0, idx=0, cnt_all=0, busy=0, done=0, error=0.
  - Internal index and timer = 0.
- Reset assertion mid-sweep aborts immediately with no done or error pulse.
- S_IDLE:
  - req=0.
  - If start=1 and IDLE=1: clear cnt_all to 0, index=0, go to S_REQ.
  - start while IDLE=0 is ignored.
- S_REQ:
  - req=1 for exactly this cycle, idx=index, timer=0, go to S_WAIT.
  - valid_contador sampled in S_REQ is stale and ignored.
- S_WAIT:
  - req=0 and idx held.
  - If valid_contador=1: write contador_out into slot[index].
    - If index==NUM_FIFOS-1, go to S_DONE.
    - Otherwise index+1, go to S_REQ.
  - Else timer+1. When timer reaches TIMEOUT-1 with no valid, go to S_ERR.
- S_DONE: done=1 for one cycle, then go to S_IDLE.
- S_ERR: error=1 for one cycle, then go to S_IDLE.
- Captured slots keep their values after an abort (partial result). Uncaptured slots stay 0.
- IDLE=0 sampled in S_REQ or S_WAIT takes priority over valid_contador: go to S_ERR, and no capture that cycle.
- start held high continuously: a new sweep begins on the cycle after S_DONE/S_ERR returns to S_IDLE, i.e. back-to-back sweeps with one idle cycle between.
- Latency with a counter that answers one cycle after req:
  - 2 cycles per index.
  - done is high in cycle 2*NUM_FIFOS+1 after the edge that samples start (cycle 9 for the defaults).
- Width rules:
  - contador_out is stored unmodified, no saturation.
  - index compares against NUM_FIFOS-1 at IDX_W bits.
  - timer is $clog2(TIMEOUT) bits and does not wrap (leaves S_WAIT first).

Decomposition:
- Shared package/include (contador_defs): state encodings (S_IDLE=0, S_REQ=1, S_WAIT=2, S_DONE=3, S_ERR=4, 3-bit), default CNT_W=5, IDX_W=3, NUM_FIFOS=4, shared with contador and its probador.
- One sub-module: timeout_timer (clear, enable, expired at TIMEOUT-1), reused by future handshake blocks.
- The FSM, index counter and capture register stay in lector_contador.

Test Plan:
- Normal sweep: reset low 3 cycles, IDLE=1, pulse start. Counter model returns 3,1,4,2 for idx 0..3 one cycle after req. Expect req pulses with idx 0,1,2,3, done in cycle 9, cnt_all=={5'd2,5'd4,5'd1,5'd3}, error=0.
- Start gated: start=1, IDLE=0 for 5 cycles. Expect req=0, busy=0, no done. Raise IDLE and expect a sweep to begin on the next edge.
- Timeout: counter model never asserts valid after the idx=1 req. Expect error pulse exactly TIMEOUT cycles after entering S_WAIT, slot0 holds its value, slots 1..3=0, no done.
- IDLE loss: drop IDLE during the S_WAIT for idx=2 while valid_contador=1 in the same cycle. Expect no capture of slot2, error pulse next cycle, then busy=0.
- Reset mid-sweep: assert reset=0 asynchronously during idx=1 S_WAIT. Expect all outputs 0 immediately (before the next edge), then a clean sweep after release.
- Back-to-back: hold start=1 across two sweeps with counts 7,0,31,1 then 0,0,0,0. Expect two done pulses 10 cycles apart and cnt_all updated to all zero after the second.
